// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end for a 256 x 32-bit data memory.
// Takes one byte-addressed load/store per valid/ready handshake, issues a
// single masked memory access, aligns and extends load data, and returns one
// response per request. Misaligned and illegal-size requests never reach memory.
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [31:0] mem_bwen,
    output logic [7:0]  mem_a,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_q
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;

    // Request fields captured at accept
    logic        we_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;
    logic [1:0]  off_p0;
    logic [31:0] bwen_p0;

    // Illegal size, or half/word not naturally aligned
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = off[0];
            2'b10:   req_bad = (off != 2'b00);
            default: req_bad = 1'b1;
        endcase
    endfunction

    // Active-low per-bit write mask: zeros over the lanes being stored
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_mask = ~(32'h0000_00FF << {off, 3'b000});
            2'b01:   lane_mask = ~(32'h0000_FFFF << {off[1], 4'b0000});
            default: lane_mask = 32'h0000_0000;
        endcase
    endfunction

    // Right-aligned store data replicated across every lane of its size
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0 and zero/sign-extend it
    function automatic logic [31:0] load_align(input logic [31:0] q, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        case (size)
            2'b00: begin
                sh  = q >> {off, 3'b000};
                b   = sh[7:0];
                ext = uns ? {24'h000000, sh[7:0]} : 32'(b);
            end
            2'b01: begin
                sh  = q >> {off[1], 4'b0000};
                h   = sh[15:0];
                ext = uns ? {16'h0000, sh[15:0]} : 32'(h);
            end
            default: begin
                sh  = q;
                b   = '0;
                h   = '0;
                ext = q;
            end
        endcase
        load_align = ext;
    endfunction

    assign accept = (state == IDLE) && req_valid && rst_n;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake ready and memory strobes; reset forces the strobes idle
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_bwen  = 32'hFFFF_FFFF;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = req_bad(req_size, req_addr[1:0]) ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_cen   = 1'b0;
                mem_wen   = ~we_p0;
                if (we_p0) mem_bwen = bwen_p0;
                state_nxt = we_p0 ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            req_ready = 1'b0;
            mem_cen   = 1'b1;
            mem_wen   = 1'b1;
            mem_bwen  = 32'hFFFF_FFFF;
        end
    end

    // Request capture at accept; these fields are only read in later states
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0   <= req_we;
            size_p0 <= req_size;
            uns_p0  <= req_unsigned;
            off_p0  <= req_addr[1:0];
            bwen_p0 <= lane_mask(req_size, req_addr[1:0]);
        end
    end

    // Memory address/data registers and the response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_a      <= 8'h00;
            mem_d      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad(req_size, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            mem_a <= req_addr[9:2];
                            mem_d <= store_data(req_size, req_wdata);
                        end
                    end
                end
                ISSUE: if (we_p0) resp_valid <= 1'b1;
                CAPTURE: begin
                    resp_rdata <= load_align(mem_q, size_p0, off_p0, uns_p0);
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store front-end for the 1 KB data memory (256 × 32-bit words, word address, active-low `cen`/`wen`, per-bit active-low `bwen`, one-cycle registered read). It accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the core over a valid/ready handshake. It converts each request into one memory access with the correct lane mask and replicated write data, then aligns and extends load data. It returns one response per request, and flags misaligned or illegal-size requests without touching memory.

## Interface
- No parameters. Memory depth and width are fixed at 256 × 32; byte address width is 10.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 10: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal-size request.
- `mem_cen` out 1: memory chip enable, active-low.
- `mem_wen` out 1: memory write enable, active-low.
- `mem_bwen` out 32: memory per-bit write mask, active-low.
- `mem_a` out 8: memory word address.
- `mem_d` out 32: memory write data.
- `mem_q` in 32: memory read data, valid the cycle after a read enable edge.

## Operation
- **State machine:** IDLE, ISSUE, CAPTURE, RESP.
- **Accept:** a request is accepted when `req_valid && req_ready`. All request fields are registered at that edge.
- **Error check at accept:** the request is an error if `req_size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0. An error request goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0. No memory access is made.
- **Legal request:** IDLE→ISSUE.
  - In ISSUE: `mem_cen`=0 and `mem_a`=`addr[9:2]`.
  - Store: `mem_wen`=0, then ISSUE→RESP.
  - Load: `mem_wen`=1, then ISSUE→CAPTURE.
- **Store lanes:**
  - SB: byte lane `addr[1:0]` has `bwen` bits 0; all other bits 1. `mem_d` = `{4{wdata[7:0]}}`.
  - SH: half lane `addr[1]` has bits 0. `mem_d` = `{2{wdata[15:0]}}`.
  - SW: `bwen`=0, `mem_d`=`wdata`.
- **CAPTURE:** take `mem_q`, shift right by 8×`addr[1:0]` (byte) or 16×`addr[1]` (half), extend per `req_unsigned`, register into `resp_rdata`, then go CAPTURE→RESP. LW passes `mem_q` unchanged.
- **RESP:** `resp_valid`=1. Outputs are held stable until `resp_ready`. At the edge where `resp_valid && resp_ready`, go to IDLE and clear `resp_valid`, `resp_err` and `resp_rdata`.
- **Outside ISSUE:** `mem_cen`=1, `mem_wen`=1 and `mem_bwen`=FFFF_FFFF. `mem_a`/`mem_d` hold the last registered values.
- **Reset gating:** `mem_cen` is forced to 1 combinationally while `rst_n`=0. Reset asserted in ISSUE therefore never writes memory.
- **Reset values** (applied at an edge with `rst_n`=0): state IDLE; `resp_valid`=0, `resp_err`=0, `resp_rdata`=0; `mem_cen`=1, `mem_wen`=1, `mem_bwen`=FFFF_FFFF; `mem_a`=0, `mem_d`=0. `req_ready`=1 from the first cycle after reset.
- **Reset mid-operation:** reset in any state discards the in-flight request and its response, with no partial response.

## Timing
- Accept edge E0.
- **Error:** `resp_valid` high from the cycle after E0.
- **Store:** ISSUE in the cycle after E0; memory writes at E1; `resp_valid` high after E1.
- **Load:** ISSUE after E0; memory reads at E1; CAPTURE after E1 with `mem_q` valid; `resp_rdata` registered at E2; `resp_valid` high after E2.
- **Back-pressure:** if `resp_ready` is held high, the next request is accepted the cycle after the response handshake. Peak throughput is one load per 4 cycles and one store per 3 cycles.
- **Ready/valid independence:** `req_ready` depends only on state, never combinationally on `req_valid`. `resp_valid` never depends on `resp_ready`.
- **Simultaneous events:** `req_valid` arriving in the same cycle as a response handshake is not accepted until IDLE.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req_valid`=1. Required: `mem_cen`=1, `resp_valid`=0 and `req_ready`=0 throughout reset; `req_ready`=1 on the first cycle after release.
- **SB lane:** SB addr 0x006, wdata 0x0000_00A5. Required in ISSUE: `mem_a`=0x01, `mem_bwen`=FF00_FFFF, `mem_d`=A5A5_A5A5, `mem_wen`=0. `resp_valid` is high 2 cycles after accept with `resp_rdata`=0.
- **Loads:** SW 0x80F1_7F02 to addr 0x010, then LB/LBU at 0x013 and LH/LHU at 0x012.
  - LB → FFFF_FF80, LBU → 0000_0080.
  - LH → FFFF_80F1, LHU → 0000_80F1.
  - LW at 0x010 → 80F1_7F02.
  - Each load has `resp_valid` 3 cycles after accept.
- **Errors:** requests LH addr 0x001, LW addr 0x002 and size 11. Required: `resp_err`=1, `resp_rdata`=0, `mem_cen` stays 1, and the next cycle shows `resp_valid`.
- **Back-pressure:** load response with `resp_ready`=0 for 5 cycles. Required: `resp_valid`/`resp_rdata` stable, `req_ready`=0, and IDLE reached one cycle after `resp_ready` rises.
- **Reset in ISSUE:** assert `rst_n`=0 during the ISSUE cycle of SW 0xDEAD_BEEF to addr 0x020. Required: a later LW at 0x020 returns the prior contents, and no response is ever issued for the aborted store.
